bp_be_tlb_perf_monitor: RTL and testbench

BP_BE_TLB_PERF_MONITOR -- requirements
Module: bp_be_tlb_perf_monitor

---
 rtl/bp_be_pkg.sv | 30 +++
 rtl/bp_be_perf_counter.sv | 38 +++
 rtl/bp_be_tlb_perf_monitor.sv | 129 ++++++++++++
 tb/tb_bp_be_tlb_perf_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module : bp_be_pkg
// Desc   : Shared types for the back-end TLB performance monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_be_pkg;

  // Upper bounds of the monitor's parameter ranges; the record struct is sized to them.
  localparam int max_ctr_width_gp = 64;
  localparam int max_id_width_gp  = 3;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    DUMP  = 2'd1,
    DONE  = 2'd2
  } bp_be_perf_state_e;

  typedef struct packed {
    logic [max_id_width_gp-1:0]  id;
    logic [max_ctr_width_gp-1:0] reads;
    logic [max_ctr_width_gp-1:0] misses;
    logic [max_ctr_width_gp-1:0] fills;
    logic [max_ctr_width_gp-1:0] clears;
  } bp_be_perf_dump_rec_s;

endpackage

`default_nettype wire

// File: rtl/bp_be_perf_counter.sv
// ============================================================================
// Module : bp_be_perf_counter
// Desc   : Single enabled event counter. Wraps by default; saturates at
//          all-ones when BP_TLB_PERF_MON_SATURATE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_be_perf_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (en_i) begin
`ifdef BP_TLB_PERF_MON_SATURATE_EN
      if (r_count != '1) begin
        r_count <= r_count + 1'b1;
      end
`else
      r_count <= r_count + 1'b1;
`endif
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_be_tlb_perf_monitor.sv
// ============================================================================
// Module : bp_be_tlb_perf_monitor
// Desc   : Per-channel TLB read/miss/fill/clear counters, dumped as a
//          valid/ready record stream after finish_i.
//          Optional: BP_TLB_PERF_MON_SATURATE_EN (saturating counters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_be_tlb_perf_monitor
  import bp_be_pkg::*;
#(
  parameter int num_tlb_p   = 2,
  parameter int ctr_width_p = 32,
  localparam int id_width_lp = (num_tlb_p > 1) ? $clog2(num_tlb_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   freeze_i,
  input  logic [num_tlb_p-1:0]   read_v_i,
  input  logic [num_tlb_p-1:0]   miss_v_i,
  input  logic [num_tlb_p-1:0]   fill_v_i,
  input  logic [num_tlb_p-1:0]   clear_i,
  input  logic                   finish_i,
  output logic                   dump_v_o,
  input  logic                   dump_ready_i,
  output logic [id_width_lp-1:0] dump_id_o,
  output logic [ctr_width_p-1:0] dump_reads_o,
  output logic [ctr_width_p-1:0] dump_misses_o,
  output logic [ctr_width_p-1:0] dump_fills_o,
  output logic [ctr_width_p-1:0] dump_clears_o,
  output logic                   done_o
);

  localparam logic [id_width_lp-1:0] c_last_id = id_width_lp'(num_tlb_p - 1);

  bp_be_perf_state_e r_state, w_state_next;
  logic [id_width_lp-1:0] r_dump_id, w_dump_id_next;
  logic w_count_en;
  logic w_handshake;

  logic [ctr_width_p-1:0] w_reads  [num_tlb_p];
  logic [ctr_width_p-1:0] w_misses [num_tlb_p];
  logic [ctr_width_p-1:0] w_fills  [num_tlb_p];
  logic [ctr_width_p-1:0] w_clears [num_tlb_p];

  // Counting is only open in COUNT; once the dump starts the snapshot is frozen.
  assign w_count_en = (r_state == COUNT) && !freeze_i;

  for (genvar g = 0; g < num_tlb_p; g++) begin : g_chan
    bp_be_perf_counter #(.width_p(ctr_width_p)) u_reads (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (w_count_en && read_v_i[g]),
      .count_o  (w_reads[g])
    );
    bp_be_perf_counter #(.width_p(ctr_width_p)) u_misses (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (w_count_en && read_v_i[g] && miss_v_i[g]),
      .count_o  (w_misses[g])
    );
    bp_be_perf_counter #(.width_p(ctr_width_p)) u_fills (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (w_count_en && fill_v_i[g]),
      .count_o  (w_fills[g])
    );
    bp_be_perf_counter #(.width_p(ctr_width_p)) u_clears (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .en_i     (w_count_en && clear_i[g]),
      .count_o  (w_clears[g])
    );
  end

  assign w_handshake = dump_v_o && dump_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= COUNT;
      r_dump_id <= '0;
    end else begin
      r_state   <= w_state_next;
      r_dump_id <= w_dump_id_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_dump_id_next = r_dump_id;
    case (r_state)
      COUNT: begin
        if (finish_i && !freeze_i) begin
          w_state_next   = DUMP;
          w_dump_id_next = '0;
        end
      end
      DUMP: begin
        if (w_handshake) begin
          if (r_dump_id == c_last_id) begin
            w_state_next = DONE;
          end else begin
            w_dump_id_next = r_dump_id + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next   = COUNT;
        w_dump_id_next = '0;
      end
    endcase
  end

  // Payload tracks the selected channel; counters are frozen outside COUNT so it holds under stall.
  assign dump_v_o      = (r_state == DUMP);
  assign done_o        = (r_state == DONE);
  assign dump_id_o     = r_dump_id;
  assign dump_reads_o  = w_reads[r_dump_id];
  assign dump_misses_o = w_misses[r_dump_id];
  assign dump_fills_o  = w_fills[r_dump_id];
  assign dump_clears_o = w_clears[r_dump_id];

endmodule

`default_nettype wire

// File: tb/tb_bp_be_tlb_perf_monitor.sv
// ============================================================================
// Module : tb_bp_be_tlb_perf_monitor
// Desc   : Scoreboard bench for bp_be_tlb_perf_monitor (2 channels, 8-bit
//          counters). Honours BP_TLB_PERF_MON_SATURATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_be_tlb_perf_monitor;
  import bp_be_pkg::*;

  localparam int NT   = 2;
  localparam int CW   = 8;
  localparam int IW   = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          freeze_i;
  logic [NT-1:0] read_v_i, miss_v_i, fill_v_i, clear_i;
  logic          finish_i;
  logic          dump_v_o;
  logic          dump_ready_i;
  logic [IW-1:0] dump_id_o;
  logic [CW-1:0] dump_reads_o, dump_misses_o, dump_fills_o, dump_clears_o;
  logic          done_o;

  int n_tests = 0;
  int n_fail  = 0;

  int m_rd[NT], m_ms[NT], m_fl[NT], m_cl[NT];
  bit m_dumping;
  bp_be_perf_dump_rec_s sb_q[$];

  bp_be_tlb_perf_monitor #(.num_tlb_p(NT), .ctr_width_p(CW)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .freeze_i     (freeze_i),
    .read_v_i     (read_v_i),
    .miss_v_i     (miss_v_i),
    .fill_v_i     (fill_v_i),
    .clear_i      (clear_i),
    .finish_i     (finish_i),
    .dump_v_o     (dump_v_o),
    .dump_ready_i (dump_ready_i),
    .dump_id_o    (dump_id_o),
    .dump_reads_o (dump_reads_o),
    .dump_misses_o(dump_misses_o),
    .dump_fills_o (dump_fills_o),
    .dump_clears_o(dump_clears_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bump(input int v);
`ifdef BP_TLB_PERF_MON_SATURATE_EN
    return (v == CMAX) ? CMAX : v + 1;
`else
    return (v + 1) % (CMAX + 1);
`endif
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NT; c++) begin
      m_rd[c] = 0; m_ms[c] = 0; m_fl[c] = 0; m_cl[c] = 0;
    end
    m_dumping = 1'b0;
    sb_q.delete();
  endtask

  // One clock of stimulus; the model counts and queues records exactly as the spec describes.
  task automatic cycle(input logic [NT-1:0] rd, input logic [NT-1:0] ms, input logic [NT-1:0] fl,
                       input logic [NT-1:0] cl, input logic frz, input logic fin);
    bp_be_perf_dump_rec_s rec;
    read_v_i = rd; miss_v_i = ms; fill_v_i = fl; clear_i = cl;
    freeze_i = frz; finish_i = fin;
    if (!m_dumping && !frz) begin
      for (int c = 0; c < NT; c++) begin
        if (rd[c])          m_rd[c] = bump(m_rd[c]);
        if (rd[c] && ms[c]) m_ms[c] = bump(m_ms[c]);
        if (fl[c])          m_fl[c] = bump(m_fl[c]);
        if (cl[c])          m_cl[c] = bump(m_cl[c]);
      end
      if (fin) begin
        m_dumping = 1'b1;
        for (int c = 0; c < NT; c++) begin
          rec        = '0;
          rec.id     = 3'(c);
          rec.reads  = 64'(m_rd[c]);
          rec.misses = 64'(m_ms[c]);
          rec.fills  = 64'(m_fl[c]);
          rec.clears = 64'(m_cl[c]);
          sb_q.push_back(rec);
        end
      end
    end
    @(posedge clk_i); #1;
    read_v_i = '0; miss_v_i = '0; fill_v_i = '0; clear_i = '0;
    freeze_i = 1'b0; finish_i = 1'b0;
  endtask

  task automatic wait_dump(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (sb_q.size() == 0) break;
      check_eq({tag, "_done_early"}, 64'(done_o), 64'd0);
      @(posedge clk_i); #1;
    end
    check_eq({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
    check_eq({tag, "_done"}, 64'(done_o), 64'd1);
    check_eq({tag, "_v_after"}, 64'(dump_v_o), 64'd0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    #1;
    model_clear();
    check_eq("rst_dump_v", 64'(dump_v_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_id", 64'(dump_id_o), 64'd0);
    check_eq("rst_reads", 64'(dump_reads_o), 64'd0);
    #2;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Scoreboard: every valid cycle is checked against the head; pop only on handshake.
  always @(negedge clk_i) begin
    if (reset_n_i && dump_v_o) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_dump_v", 64'(dump_v_o), 64'd0);
      end else begin
        check_eq("rec_id", 64'(dump_id_o), 64'(sb_q[0].id));
        check_eq("rec_reads", 64'(dump_reads_o), sb_q[0].reads);
        check_eq("rec_misses", 64'(dump_misses_o), sb_q[0].misses);
        check_eq("rec_fills", 64'(dump_fills_o), sb_q[0].fills);
        check_eq("rec_clears", 64'(dump_clears_o), sb_q[0].clears);
        if (dump_ready_i) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset_n_i = 1'b0; freeze_i = 1'b0; finish_i = 1'b0; dump_ready_i = 1'b0;
    read_v_i = '0; miss_v_i = '0; fill_v_i = '0; clear_i = '0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("init_dump_v", 64'(dump_v_o), 64'd0);
    check_eq("init_done", 64'(done_o), 64'd0);
    check_eq("init_id", 64'(dump_id_o), 64'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // 5 reads on ch0, 3 of them misses; stray misses without reads
    dump_ready_i = 1'b1;
    repeat (3) cycle(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (2) cycle(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_eq("a_first_v", 64'(dump_v_o), 64'd1);
    wait_dump("a");
    cycle(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    check_eq("a_done_hold", 64'(done_o), 64'd1);
    check_eq("a_no_redump", 64'(dump_v_o), 64'd0);
    do_reset();

    // Frozen fills, mixed events, frozen finish, then a stalled dump
    repeat (4) cycle(2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0);
    repeat (2) cycle(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    check_eq("b_frozen_finish", 64'(dump_v_o), 64'd0);
    dump_ready_i = 1'b0;
    cycle(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      check_eq("c_stall_v", 64'(dump_v_o), 64'd1);
      check_eq("c_stall_id", 64'(dump_id_o), 64'd0);
      cycle(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b1);
    end
    dump_ready_i = 1'b1;
    wait_dump("c");
    do_reset();

    // 260 reads on ch0 exercise wrap / saturation
    repeat (260) cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
`ifdef BP_TLB_PERF_MON_SATURATE_EN
    check_eq("d_reads", 64'(dump_reads_o), 64'd255);
`else
    check_eq("d_reads", 64'(dump_reads_o), 64'd4);
`endif
    wait_dump("d");
    do_reset();

    // Reset in the middle of a dump
    repeat (3) cycle(2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    check_eq("f_id_after_rec0", 64'(dump_id_o), 64'd1);
    do_reset();
    for (int s = 0; s < 3; s++) begin
      check_eq("f_post_rst_v", 64'(dump_v_o), 64'd0);
      check_eq("f_post_rst_done", 64'(done_o), 64'd0);
      cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    wait_dump("f");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
